// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises RST deassertion, holds for MIN_HOLD cycles,
// then releases NCH active-low channel resets in ascending order, GAP cycles apart.
module rst_sequencer #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HOLD    = 8,
  parameter int GAP         = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           SW_RST,
  output logic [NCH-1:0] RST_OUT,
  output logic           READY,
  output logic [1:0]     STATE
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MIN_HOLD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
  localparam logic [4:0] LAST_IDX  = 5'(NCH - 1);

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_shift;
  logic [7:0]             r_hold_cnt, w_hold_nxt;
  logic [7:0]             r_gap_cnt, w_gap_nxt;
  logic [4:0]             r_idx, w_idx_nxt;
  logic [NCH-1:0]         r_rst_out, w_out_nxt;
  logic                   r_ready, w_ready_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // HOLD is entered on the same edge the last synchroniser stage becomes 1.
  assign w_sync_shift = {r_sync[SYNC_STAGES-2:0], 1'b1};

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_idx_nxt   = r_idx;
    w_out_nxt   = r_rst_out;
    w_ready_nxt = r_ready;
    if (r_state == ST_SYNC) begin
      if (w_sync_shift[SYNC_STAGES-1]) begin
        w_state_nxt = ST_HOLD;
        w_hold_nxt  = '0;
      end
    end else if (SW_RST) begin
      w_state_nxt = ST_HOLD;
      w_hold_nxt  = '0;
      w_gap_nxt   = '0;
      w_idx_nxt   = '0;
      w_out_nxt   = '0;
      w_ready_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_out_nxt[0] = 1'b1;
            w_idx_nxt    = 5'd1;
            w_gap_nxt    = '0;
            if (NCH == 1) begin
              w_state_nxt = ST_RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_RELEASE;
            end
          end else begin
            w_hold_nxt = sat_inc8(r_hold_cnt);
          end
        end
        ST_RELEASE: begin
          if (r_gap_cnt == GAP_LAST) begin
            for (int k = 0; k < NCH; k++) begin
              if (r_idx == 5'(k)) w_out_nxt[k] = 1'b1;
            end
            w_idx_nxt = r_idx + 5'd1;
            w_gap_nxt = '0;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = ST_RUN;
              w_ready_nxt = 1'b1;
            end
          end else begin
            w_gap_nxt = sat_inc8(r_gap_cnt);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync <= '0;
    end else begin
      r_sync <= w_sync_shift;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_SYNC;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_idx      <= '0;
      r_rst_out  <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_idx      <= w_idx_nxt;
      r_rst_out  <= w_out_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign RST_OUT = r_rst_out;
  assign READY   = r_ready;
  assign STATE   = r_state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: two parameterisations share RST/SW_RST and are checked
// every cycle against an edge-count model of the release schedule.
module tb_rst_sequencer;

  localparam int NCH_A = 4, SS_A = 2, MH_A = 8, GAP_A = 4;
  localparam int NCH_B = 1, SS_B = 3, MH_B = 1, GAP_B = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SW_RST;
  logic [3:0] out_a;
  logic       rdy_a;
  logic [1:0] st_a;
  logic [0:0] out_b;
  logic       rdy_b;
  logic [1:0] st_b;

  int vectors     = 0;
  int miscompares = 0;
  int n           = 0;
  int elast_a     = 0;
  int elast_b     = 0;

  always #5 CLK = ~CLK;

  rst_sequencer #(.NCH(NCH_A), .SYNC_STAGES(SS_A), .MIN_HOLD(MH_A), .GAP(GAP_A)) dut_a (
    .CLK(CLK), .RST(RST), .SW_RST(SW_RST), .RST_OUT(out_a), .READY(rdy_a), .STATE(st_a)
  );

  rst_sequencer #(.NCH(NCH_B), .SYNC_STAGES(SS_B), .MIN_HOLD(MH_B), .GAP(GAP_B)) dut_b (
    .CLK(CLK), .RST(RST), .SW_RST(SW_RST), .RST_OUT(out_b), .READY(rdy_b), .STATE(st_b)
  );

  // Channel k is released at edge base + k*gap; base is set by sync depth or the last SW_RST.
  function automatic int m_base(input int elast, input int ss, input int mh);
    return ((elast > ss) ? elast : ss) + mh;
  endfunction

  function automatic logic [15:0] m_out(input int cnt, input int elast, input int nch,
                                        input int ss, input int mh, input int gap);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < nch; k++) begin
      if (cnt >= m_base(elast, ss, mh) + k * gap) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic m_ready(input int cnt, input int elast, input int nch,
                                   input int ss, input int mh, input int gap);
    return cnt >= m_base(elast, ss, mh) + (nch - 1) * gap;
  endfunction

  function automatic logic [1:0] m_state(input int cnt, input int elast, input int nch,
                                         input int ss, input int mh, input int gap);
    int base;
    base = m_base(elast, ss, mh);
    if (cnt < ss) return 2'd0;
    if (cnt < base) return 2'd1;
    if (cnt < base + (nch - 1) * gap) return 2'd2;
    return 2'd3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_rst_out", 32'(out_a), 32'(m_out(n, elast_a, NCH_A, SS_A, MH_A, GAP_A)));
    chk("a_ready",   32'(rdy_a), 32'(m_ready(n, elast_a, NCH_A, SS_A, MH_A, GAP_A)));
    chk("a_state",   32'(st_a),  32'(m_state(n, elast_a, NCH_A, SS_A, MH_A, GAP_A)));
    chk("b_rst_out", 32'(out_b), 32'(m_out(n, elast_b, NCH_B, SS_B, MH_B, GAP_B)));
    chk("b_ready",   32'(rdy_b), 32'(m_ready(n, elast_b, NCH_B, SS_B, MH_B, GAP_B)));
    chk("b_state",   32'(st_b),  32'(m_state(n, elast_b, NCH_B, SS_B, MH_B, GAP_B)));
  endtask

  // Drive SW_RST, take one rising edge, advance the model, sample on the falling edge.
  task automatic tick(input logic sw);
    SW_RST = sw;
    @(posedge CLK);
    if (RST) begin
      n++;
      if (sw && n > SS_A) elast_a = n;
      if (sw && n > SS_B) elast_b = n;
    end
    @(negedge CLK);
    check_all();
  endtask

  task automatic run_to(input int target);
    while (n < target) tick(1'b0);
  endtask

  // Sub-period RST pulse placed between a falling and the next rising edge.
  task automatic rst_pulse();
    #1 RST = 1'b0;
    #1;
    chk("async_drop_a", 32'(out_a), 32'd0);
    chk("async_drop_rdy", 32'(rdy_a), 32'd0);
    chk("async_drop_st", 32'(st_a), 32'd0);
    chk("async_drop_b", 32'(out_b), 32'd0);
    #2 RST = 1'b1;
    n       = 0;
    elast_a = 0;
    elast_b = 0;
  endtask

  initial begin
    int r;
    RST    = 1'b0;
    SW_RST = 1'b0;
    #2;
    check_all();
    @(negedge CLK);
    RST = 1'b1;

    // Power-up release schedule, both parameterisations
    run_to(3);
    chk("b_e3_out", 32'(out_b), 32'd0);
    run_to(4);
    chk("b_e4_out", 32'(out_b), 32'd1);
    chk("b_e4_rdy", 32'(rdy_b), 32'd1);
    run_to(9);
    chk("a_e9_out", 32'(out_a), 32'h0);
    run_to(10);
    chk("a_e10_out", 32'(out_a), 32'h1);
    run_to(14);
    chk("a_e14_out", 32'(out_a), 32'h3);
    run_to(18);
    chk("a_e18_out", 32'(out_a), 32'h7);
    run_to(21);
    chk("a_e21_rdy", 32'(rdy_a), 32'd0);
    run_to(22);
    chk("a_e22_out", 32'(out_a), 32'hF);
    chk("a_e22_rdy", 32'(rdy_a), 32'd1);
    chk("a_e22_st",  32'(st_a),  32'd3);

    // Single-edge software reset in RUN
    run_to(29);
    tick(1'b1);
    chk("sw1_out", 32'(out_a), 32'h0);
    chk("sw1_rdy", 32'(rdy_a), 32'd0);
    chk("sw1_st",  32'(st_a),  32'd1);
    run_to(37);
    chk("sw1_e37", 32'(out_a), 32'h0);
    run_to(38);
    chk("sw1_e38", 32'(out_a), 32'h1);
    run_to(49);
    chk("sw1_e49_rdy", 32'(rdy_a), 32'd0);
    run_to(50);
    chk("sw1_e50_rdy", 32'(rdy_a), 32'd1);

    // Short RST pulse mid-release, then restart from edge 1
    rst_pulse();
    run_to(15);
    chk("pre_pulse_out", 32'(out_a), 32'h3);
    rst_pulse();
    run_to(9);
    chk("restart_e9", 32'(out_a), 32'h0);
    run_to(10);
    chk("restart_e10", 32'(out_a), 32'h1);

    // Multi-edge software reset, edges 30..34
    run_to(29);
    repeat (5) tick(1'b1);
    run_to(41);
    chk("sw5_e41", 32'(out_a), 32'h0);
    run_to(42);
    chk("sw5_e42", 32'(out_a), 32'h1);
    run_to(60);

    // SW_RST held through power-on reset: ignored in SYNC, holds HOLD afterwards
    RST     = 1'b0;
    n       = 0;
    elast_a = 0;
    elast_b = 0;
    tick(1'b1);
    tick(1'b1);
    RST = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("swpor_e2_st", 32'(st_a), 32'd1);
    repeat (3) tick(1'b1);
    chk("swpor_e5_st", 32'(st_a), 32'd1);
    run_to(12);
    chk("swpor_e12", 32'(out_a), 32'h0);
    run_to(13);
    chk("swpor_e13", 32'(out_a), 32'h1);
    run_to(30);

    // Randomised SW_RST bursts and RST pulses
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) rst_pulse();
      else tick(r < 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter NCH, default 4, number of reset output channels; legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth in flops; legal range 2..4.
REQ-003 Parameter MIN_HOLD, default 8, minimum held-reset cycles before first release; legal range 1..255.
REQ-004 Parameter GAP, default 4, cycles between consecutive channel releases; legal range 1..255.
REQ-005 Port CLK, input, 1 bit: the single clock; all state changes on rising edge except asynchronous reset.
REQ-006 Port RST, input, 1 bit: reset is asynchronous and active-low.
REQ-007 Port SW_RST, input, 1 bit: synchronous active-high software reset request, sampled on CLK.
REQ-008 Port RST_OUT, output, NCH bits: per-channel active-low resets, each driven directly by a flop.
REQ-009 Port READY, output, 1 bit: high when every channel is released.
REQ-010 Port STATE, output, 2 bits: current FSM state, SYNC=0, HOLD=1, RELEASE=2, RUN=3.

Function
REQ-011 The FSM SHALL have exactly four states: SYNC, HOLD, RELEASE, RUN.
REQ-012 SYNC: a SYNC_STAGES-deep chain of flops, cleared by RST, SHALL shift in constant 1; SYNC SHALL exit to HOLD when the last stage is 1.
REQ-013 HOLD: an 8-bit counter SHALL count cycles, and HOLD SHALL exit to RELEASE when MIN_HOLD cycles have been counted.
REQ-014 RELEASE: channels SHALL deassert in ascending index order, one channel every GAP cycles, and RELEASE SHALL exit to RUN when channel NCH-1 is released.
REQ-015 Edges are numbered with edge 1 as the first rising CLK edge after RST rises.
REQ-016 With SW_RST low throughout, RST_OUT[k] SHALL go high at edge SYNC_STAGES+MIN_HOLD+k*GAP.
REQ-017 READY SHALL go high on the same edge as RST_OUT[NCH-1] and STATE SHALL read RUN from that edge onward.
REQ-018 With NCH=1, RELEASE SHALL last one edge: RST_OUT[0] and READY rise together.
REQ-019 A released channel SHALL stay high until RST goes low or SW_RST is sampled high.
REQ-020 RST_OUT SHALL be monotonic during a sequence: no released channel re-asserts except through REQ-021 or REQ-025.
REQ-021 SW_RST sampled high at edge e in HOLD, RELEASE or RUN SHALL, after edge e, force all RST_OUT low, READY low, STATE=HOLD and the hold counter to zero.
REQ-022 While SW_RST is held high, the block SHALL remain in HOLD with the counter held at zero.
REQ-023 With e_last the last edge SW_RST is sampled high, RST_OUT[k] SHALL rise at edge e_last+MIN_HOLD+k*GAP.
REQ-024 SW_RST SHALL be ignored in SYNC.
REQ-025 SW_RST SHALL NOT bypass the synchroniser: the synchroniser chain stays at 1 through a software reset.
REQ-026 The counters SHALL NOT wrap: the gap counter reloads on each channel release and the hold counter saturates.

Reset
REQ-027 RST low SHALL asynchronously, without a CLK edge, force RST_OUT all 0, READY 0, STATE=SYNC, the synchroniser chain to 0 and all counters to 0.
REQ-028 RST low for any duration, including less than one CLK period, SHALL restart the full sequence from edge 1 after RST rises.
REQ-029 RST falling mid-RELEASE or mid-RUN SHALL drop every released channel immediately, asynchronously.
REQ-030 The deassertion of RST SHALL affect outputs only through the synchroniser; no output changes on RST rising.

Verification
REQ-031 Power-up with defaults, RST released -> RST_OUT=4'b0001 at edge 10, 0011 at 14, 0111 at 18, 1111 and READY=1 and STATE=3 at edge 22.
REQ-032 In RUN, SW_RST high for the single edge 30 -> RST_OUT=0 and READY=0 after edge 30; RST_OUT[0]=1 at edge 38; READY=1 at edge 50.
REQ-033 SW_RST high on edges 30-34 -> outputs stay 0 through edge 41; RST_OUT[0] rises at edge 42.
REQ-034 RST pulsed low for 0.3 CLK period while RST_OUT=4'b0011 -> RST_OUT=0 before the next edge; the sequence restarts with RST_OUT[0] rising at relative edge 10.
REQ-035 Parameters NCH=1, SYNC_STAGES=3, MIN_HOLD=1 -> RST_OUT[0] and READY rise together at edge 4.
REQ-036 SW_RST held high from before RST rises -> it is ignored in SYNC; HOLD begins at edge 2 with the counter held at 0; release occurs MIN_HOLD edges after SW_RST drops.
